// File: rtl/morse_encoder_if.sv
// ---------------------------------------------------------------------------
// morse_encoder_if
// Character handshake between an upstream source and the Morse encoder.
//   char_valid : source has a character on char_data
//   char_data  : 8-bit ASCII code
//   char_ready : encoder can accept; transfer when char_valid && char_ready
// Modports:
//   master : upstream source (drives valid/data, observes ready)
//   slave  : encoder (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface morse_encoder_if;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;

    modport master (
        output char_valid,
        output char_data,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_data,
        output char_ready
    );
endinterface

// File: rtl/morse_encoder.sv
// ---------------------------------------------------------------------------
// morse_encoder
// Accepts one ASCII character at a time and keys it out with ITU Morse
// timing (dot = U, dash = 3U, element gap = U, letter gap = 3U, word gap
// completes to 7U). In parallel it pulses a 2-bit symbol stream that the
// Morse letter decoder consumes (01 dot, 10 dash, 11 letter end).
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   bus     : character handshake (slave side)
//   key     : keying output, 1 = tone on
//   symbol  : per-element pulse, 00 idle / 01 dot / 10 dash / 11 send
//   busy    : high whenever the encoder is not idle
//   err     : one-cycle pulse when an unsupported character is accepted
// Parameter:
//   UNIT_CYCLES : clock cycles per Morse time unit (>= 1)
// All outputs are registered; they are loaded from next-state values so a
// transfer at edge k shows key/symbol/busy in cycle k+1.
// ---------------------------------------------------------------------------
module morse_encoder #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    morse_encoder_if.slave       bus,
    output logic                 key,
    output logic [1:0]           symbol,
    output logic                 busy,
    output logic                 err
);

    localparam int CW = $clog2(4 * UNIT_CYCLES + 1);
    typedef logic [CW-1:0] cnt_t;

    // Counter loads are duration-1; a state exits on the cycle the counter is 0.
    localparam cnt_t CNT_ZERO  = cnt_t'(0);
    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cnt_t DOT_LOAD  = cnt_t'(UNIT_CYCLES - 1);
    localparam cnt_t DASH_LOAD = cnt_t'(3 * UNIT_CYCLES - 1);
    localparam cnt_t LGAP_LOAD = cnt_t'(3 * UNIT_CYCLES - 1);
    localparam cnt_t WGAP_LOAD = cnt_t'(4 * UNIT_CYCLES - 1);

    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_SEND = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MARK = 3'd1,
        ST_GAP  = 3'd2,
        ST_LGAP = 3'd3,
        ST_WGAP = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // ITU alphabet lookup on an uppercase code: {len[2:0], pat[3:0]}.
    // len = 0 marks a non-letter. Elements go out from pat[len-1] to pat[0],
    // 1 = dash, 0 = dot.
    function automatic logic [6:0] morse_lut(input logic [7:0] c);
        logic [6:0] r;
        case (c)
            8'd65:   r = {3'd2, 4'b0001}; // A .-
            8'd66:   r = {3'd4, 4'b1000}; // B -...
            8'd67:   r = {3'd4, 4'b1010}; // C -.-.
            8'd68:   r = {3'd3, 4'b0100}; // D -..
            8'd69:   r = {3'd1, 4'b0000}; // E .
            8'd70:   r = {3'd4, 4'b0010}; // F ..-.
            8'd71:   r = {3'd3, 4'b0110}; // G --.
            8'd72:   r = {3'd4, 4'b0000}; // H ....
            8'd73:   r = {3'd2, 4'b0000}; // I ..
            8'd74:   r = {3'd4, 4'b0111}; // J .---
            8'd75:   r = {3'd3, 4'b0101}; // K -.-
            8'd76:   r = {3'd4, 4'b0100}; // L .-..
            8'd77:   r = {3'd2, 4'b0011}; // M --
            8'd78:   r = {3'd2, 4'b0010}; // N -.
            8'd79:   r = {3'd3, 4'b0111}; // O ---
            8'd80:   r = {3'd4, 4'b0110}; // P .--.
            8'd81:   r = {3'd4, 4'b1101}; // Q --.-
            8'd82:   r = {3'd3, 4'b0010}; // R .-.
            8'd83:   r = {3'd3, 4'b0000}; // S ...
            8'd84:   r = {3'd1, 4'b0001}; // T -
            8'd85:   r = {3'd3, 4'b0001}; // U ..-
            8'd86:   r = {3'd4, 4'b0001}; // V ...-
            8'd87:   r = {3'd3, 4'b0011}; // W .--
            8'd88:   r = {3'd4, 4'b1001}; // X -..-
            8'd89:   r = {3'd4, 4'b1011}; // Y -.--
            8'd90:   r = {3'd4, 4'b1100}; // Z --..
            default: r = {3'd0, 4'b0000};
        endcase
        return r;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    cnt_t       cnt_r;
    cnt_t       cnt_next_s;
    logic [1:0] idx_r;
    logic [1:0] idx_next_s;
    logic [1:0] idx_dec_s;
    logic [3:0] pat_r;
    logic [3:0] pat_next_s;
    logic [1:0] sym_next_s;

    logic       key_r;
    logic [1:0] symbol_r;
    logic       busy_r;
    logic       err_r;
    logic       char_ready_r;

    logic [7:0] upper_s;
    logic [6:0] lut_s;
    logic [2:0] lut_len_s;
    logic [3:0] lut_pat_s;
    logic [1:0] first_idx_s;
    logic       first_elem_s;
    logic       next_elem_s;
    logic       accept_s;

    // Fold lowercase onto uppercase and look the character up.
    always_comb begin
        if ((bus.char_data >= 8'd97) && (bus.char_data <= 8'd122)) begin
            upper_s = bus.char_data - 8'd32;
        end else begin
            upper_s = bus.char_data;
        end
        lut_s        = morse_lut(upper_s);
        lut_len_s    = lut_s[6:4];
        lut_pat_s    = lut_s[3:0];
        first_idx_s  = 2'(lut_len_s - 3'd1);
        first_elem_s = lut_pat_s[first_idx_s];
        idx_dec_s    = idx_r - 2'd1;
        next_elem_s  = pat_r[idx_dec_s];
        accept_s     = bus.char_valid && (state_r == ST_IDLE);
    end

    // Next-state, counter and symbol decode for the keying FSM.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        pat_next_s   = pat_r;
        sym_next_s   = SYM_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (lut_len_s != 3'd0) begin
                        state_next_s = ST_MARK;
                        idx_next_s   = first_idx_s;
                        pat_next_s   = lut_pat_s;
                        cnt_next_s   = first_elem_s ? DASH_LOAD : DOT_LOAD;
                        sym_next_s   = first_elem_s ? SYM_DASH : SYM_DOT;
                    end else if (bus.char_data == 8'd32) begin
                        state_next_s = ST_WGAP;
                        cnt_next_s   = WGAP_LOAD;
                    end else begin
                        state_next_s = ST_ERR;
                        cnt_next_s   = CNT_ZERO;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MARK: begin
                if (cnt_r == CNT_ZERO) begin
                    if (idx_r != 2'd0) begin
                        state_next_s = ST_GAP;
                        cnt_next_s   = DOT_LOAD;
                    end else begin
                        state_next_s = ST_LGAP;
                        cnt_next_s   = LGAP_LOAD;
                        sym_next_s   = SYM_SEND;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_MARK;
                    idx_next_s   = idx_dec_s;
                    cnt_next_s   = next_elem_s ? DASH_LOAD : DOT_LOAD;
                    sym_next_s   = next_elem_s ? SYM_DASH : SYM_DOT;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            ST_LGAP, ST_WGAP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_IDLE;
                    pat_next_s   = 4'b0000;
                    idx_next_s   = 2'd0;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            ST_ERR: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
                idx_next_s   = 2'd0;
                pat_next_s   = 4'b0000;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any letter in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            idx_r        <= 2'd0;
            pat_r        <= 4'b0000;
            key_r        <= 1'b0;
            symbol_r     <= SYM_IDLE;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
            char_ready_r <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            idx_r        <= idx_next_s;
            pat_r        <= pat_next_s;
            key_r        <= (state_next_s == ST_MARK);
            symbol_r     <= sym_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            err_r        <= (state_next_s == ST_ERR);
            char_ready_r <= (state_next_s == ST_IDLE);
        end
    end

    assign key            = key_r;
    assign symbol         = symbol_r;
    assign busy           = busy_r;
    assign err            = err_r;
    assign bus.char_ready = char_ready_r;

endmodule
